// File: rtl/fetch_queue.sv
// Front-end fetch stage: issues sequential ROM reads with credit-based flow control
// and buffers {pc, instr} pairs in a small FIFO in front of the execute stage.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       rom_en,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [31:0]                rom_data,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [$clog2(DEPTH+1)-1:0] fill_level
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit;

    // Output handshake: an entry transfers on a cycle where out_valid && out_ready;
    // while out_valid && !out_ready the head entry and its PC are held unchanged.
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect;

    // A read is only issued if a slot is guaranteed for its response.
    assign credit = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
    assign issue  = rst_n & ~redirect & (credit < (CW+1)'(DEPTH));

    assign rom_en     = issue;
    assign rom_addr   = fetch_pc[ADDR_W-1:0];
    assign fill_level = count;
    assign out_instr  = out_valid ? mem_instr[rd_ptr] : NOP;
    assign out_pc     = out_valid ? mem_pc[rd_ptr]    : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            // Flush wins over any same-cycle pop/push and drops the outstanding read.
            fetch_pc <= redirect_pc & ~32'h3;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_INC;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= inflight_pc;
            mem_instr[wr_ptr] <= rom_data;
        end
    end

endmodule
